psum_drain: RTL and testbench
=============================

PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 SHALL have parameter col, default 8, number of output lanes (one per MAC column).
REQ-002 SHALL have parameter psum_bw, default 16, signed partial-sum width per lane.
REQ-003 SHALL have parameter addr_bw, default 11, psum SRAM address width.
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a drain job.
REQ-007 SHALL have port len  input  addr_bw  number of vectors in the job, sampled on start.
REQ-008 SHALL have port base_addr  input  addr_bw  first SRAM address, sampled on start.
REQ-009 SHALL have port first_pass  input  1  1 = overwrite SRAM, 0 = accumulate into SRAM, sampled on start.
REQ-010 SHALL have port last_pass  input  1  marks the final accumulation pass, sampled on start.
REQ-011 SHALL have port ofifo_valid  input  1  OFIFO holds at least one full row.
REQ-012 SHALL have port ofifo_output  input  col*psum_bw  OFIFO head row, lane 0 in the LSBs.
REQ-013 SHALL have port ofifo_rd  output  1  OFIFO pop strobe.
REQ-014 SHALL have ports sram_cen, sram_wen  output  1 each  active-low chip enable / write enable.
REQ-015 SHALL have ports sram_addr  output  addr_bw, sram_din  output  col*psum_bw, sram_dout  input  col*psum_bw.
REQ-016 SHALL have ports busy  output  1 and done  output  1 (one-cycle pulse at job end).

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, ADD, WRITE, DONE.
REQ-018 SHALL move IDLE->FETCH on start with len!=0, and IDLE->DONE on start with len==0.
REQ-019 SHALL, in FETCH with ofifo_valid=1, assert ofifo_rd for exactly that cycle, latch ofifo_output, issue an SRAM read at the current address when first_pass=0, and go to ADD; FETCH with ofifo_valid=0 SHALL stall with no strobes.
REQ-020 SHALL treat SRAM read latency as 1 cycle; sram_dout is valid in ADD.
REQ-021 SHALL compute per lane, in ADD, result = latched value (first_pass=1) or latched value + sram_dout (first_pass=0), signed and saturated to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
REQ-022 SHALL, in WRITE, drive sram_cen=0, sram_wen=0, sram_din=registered result, then increment address and count.
REQ-023 SHALL go WRITE->FETCH while count<len, and WRITE->DONE after the len-th write.
REQ-024 SHALL pulse done for exactly one cycle in DONE, then return to IDLE.
REQ-025 SHALL hold busy=1 in every state except IDLE.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL wrap sram_addr modulo 2^addr_bw.
REQ-028 SHALL drive sram_cen=1, sram_wen=1 in every cycle with no access; sustained throughput SHALL be one vector per 3 cycles.

Reset
REQ-029 SHALL, on reset, force IDLE with ofifo_rd=0, sram_cen=1, sram_wen=1, sram_addr=0, sram_din=0, busy=0, done=0, and clear count.
REQ-030 SHALL, on reset mid-job, abandon the job with no further SRAM write and no done pulse.

Configuration
REQ-031 SHALL, with PSUM_RELU_EN defined, clamp each negative lane result to 0 when last_pass=1; otherwise results SHALL be written unmodified.
REQ-032 SHALL, without PSUM_RELU_EN, ignore last_pass entirely.

Structure
REQ-033 SHALL place the state enumeration and the COL/PSUM_BW/ADDR_BW defaults in shared package psum_pkg.
REQ-034 SHALL use one sub-module, psum_lane_add (saturating add plus optional ReLU), instantiated col times.

Verification
REQ-035 SHALL cover first_pass=1, len=2, base_addr=5, rows all-lanes 3 then 7 -> SRAM[5]=3s, SRAM[6]=7s, one done pulse.
REQ-036 SHALL cover first_pass=0, SRAM[0] lanes=100, OFIFO lanes=-30 -> SRAM[0] lanes=70.
REQ-037 SHALL cover saturation: SRAM lane 32000 + OFIFO lane 1000 -> 32767; -32000 + -1000 -> -32768.
REQ-038 SHALL cover PSUM_RELU_EN with last_pass=1, sum -5 -> 0; without the macro -> -5.
REQ-039 SHALL cover stall and reset: ofifo_valid low 10 cycles in FETCH -> no strobes; reset during ADD -> IDLE, no write, done=0.
REQ-040 SHALL cover len=0 -> done one cycle after start, no SRAM access; start during busy -> ignored.

Source files
------------

// File: rtl/psum_pkg.sv
//------------------------------------------------------------------------------
// Module   : psum_pkg
// Purpose  : Shared defaults and FSM state encoding for the partial-sum drain
//            engine (psum_drain) and its per-lane adder (psum_lane_add).
// Contents : COL / PSUM_BW / ADDR_BW defaults, 3-bit drain FSM state codes.
// Options  : none here (PSUM_RELU_EN is consumed by psum_lane_add).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package psum_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int ADDR_BW = 11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage : psum_pkg

`default_nettype wire

// File: rtl/psum_lane_add.sv
//------------------------------------------------------------------------------
// Module   : psum_lane_add
// Purpose  : One lane of the drain datapath. Optionally accumulates the OFIFO
//            value with the SRAM read value, saturates to the signed psum
//            range and, when PSUM_RELU_EN is defined, clamps negatives to 0
//            on the final pass.
// Ports    : i_a    - latched OFIFO lane value (signed)
//            i_b    - SRAM read lane value (signed)
//            i_acc  - 1 = i_a + i_b, 0 = i_a alone
//            i_relu - final-pass marker (only used with PSUM_RELU_EN)
//            o_sum  - saturated (and optionally rectified) lane result
// Options  : PSUM_RELU_EN - enables the last-pass ReLU clamp.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module psum_lane_add
  import psum_pkg::*;
#(
  parameter int psum_bw = PSUM_BW
) (
  input  logic [psum_bw-1:0] i_a,
  input  logic [psum_bw-1:0] i_b,
  input  logic               i_acc,
  input  logic               i_relu,
  output logic [psum_bw-1:0] o_sum
);

  logic [psum_bw:0]   w_ext_a;
  logic [psum_bw:0]   w_ext_b;
  logic [psum_bw:0]   w_sum;
  logic [psum_bw-1:0] w_sat;

  assign w_ext_a = {i_a[psum_bw-1], i_a};
  assign w_ext_b = {i_b[psum_bw-1], i_b};
  assign w_sum   = i_acc ? (w_ext_a + w_ext_b) : w_ext_a;

  // One guard bit is enough: disagreement between the guard and the sign bit
  // means the true sum left the psum_bw range, and the guard gives direction.
  always_comb begin
    if (w_sum[psum_bw] != w_sum[psum_bw-1]) begin
      if (w_sum[psum_bw]) w_sat = {1'b1, {(psum_bw-1){1'b0}}};
      else                w_sat = {1'b0, {(psum_bw-1){1'b1}}};
    end else begin
      w_sat = w_sum[psum_bw-1:0];
    end
  end

`ifdef PSUM_RELU_EN
  assign o_sum = (i_relu && w_sat[psum_bw-1]) ? '0 : w_sat;
`else
  // Final-pass marker has no effect in this build.
  logic w_unused_relu;
  assign w_unused_relu = i_relu;
  assign o_sum = w_sat;
`endif

endmodule : psum_lane_add

`default_nettype wire

// File: rtl/psum_drain.sv
//------------------------------------------------------------------------------
// Module   : psum_drain
// Purpose  : Drains rows of partial sums from the OFIFO into the psum SRAM,
//            either overwriting (first pass) or read-modify-write accumulating
//            with per-lane saturation. One vector every 3 cycles
//            (FETCH -> ADD -> WRITE).
// Ports    : clk, reset (sync, active-high)
//            start/len/base_addr/first_pass/last_pass - job launch, sampled
//              on start while idle
//            ofifo_valid/ofifo_output/ofifo_rd - OFIFO pop interface
//            sram_cen/sram_wen (active low), sram_addr, sram_din, sram_dout
//              - single-port SRAM, 1-cycle read latency
//            busy - high whenever not idle; done - one-cycle end-of-job pulse
// Options  : PSUM_RELU_EN - last-pass ReLU in every lane (see psum_lane_add).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module psum_drain
  import psum_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int addr_bw = ADDR_BW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw-1:0]     len,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic                   first_pass,
  input  logic                   last_pass,
  input  logic                   ofifo_valid,
  input  logic [col*psum_bw-1:0] ofifo_output,
  output logic                   ofifo_rd,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic [addr_bw-1:0]     sram_addr,
  output logic [col*psum_bw-1:0] sram_din,
  input  logic [col*psum_bw-1:0] sram_dout,
  output logic                   busy,
  output logic                   done
);

  logic [2:0]             r_state;
  logic [addr_bw-1:0]     r_len;
  logic [addr_bw-1:0]     r_count;
  logic [addr_bw-1:0]     r_addr;
  logic                   r_first;
  logic                   r_last;
  logic [col*psum_bw-1:0] r_data;
  logic [col*psum_bw-1:0] r_result;

  logic [col*psum_bw-1:0] w_lane_result;
  logic [addr_bw-1:0]     w_count_nxt;

  assign w_count_nxt = r_count + {{(addr_bw-1){1'b0}}, 1'b1};

  for (genvar gi = 0; gi < col; gi++) begin : g_lane
    psum_lane_add #(
      .psum_bw (psum_bw)
    ) u_lane_add (
      .i_a    (r_data[gi*psum_bw +: psum_bw]),
      .i_b    (sram_dout[gi*psum_bw +: psum_bw]),
      .i_acc  (~r_first),
      .i_relu (r_last),
      .o_sum  (w_lane_result[gi*psum_bw +: psum_bw])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_len    <= '0;
      r_count  <= '0;
      r_addr   <= '0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_data   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len   <= len;
            r_addr  <= base_addr;
            r_first <= first_pass;
            r_last  <= last_pass;
            r_count <= '0;
            r_state <= (len == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (ofifo_valid) begin
            r_data  <= ofifo_output;
            r_state <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_result <= w_lane_result;
          r_state  <= ST_WRITE;
        end
        ST_WRITE: begin
          // Address is addr_bw wide, so it wraps naturally at 2^addr_bw.
          r_addr  <= r_addr + {{(addr_bw-1){1'b0}}, 1'b1};
          r_count <= w_count_nxt;
          r_state <= (w_count_nxt == r_len) ? ST_DONE : ST_FETCH;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are combinational from state; reset masks them so nothing is
  // issued in the cycle reset is asserted, even mid-job.
  always_comb begin
    ofifo_rd = 1'b0;
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    if (!reset) begin
      case (r_state)
        ST_FETCH: begin
          if (ofifo_valid) begin
            ofifo_rd = 1'b1;
            if (!r_first) sram_cen = 1'b0;  // read for accumulate
          end
        end
        ST_WRITE: begin
          sram_cen = 1'b0;
          sram_wen = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign sram_addr = r_addr;
  assign sram_din  = r_result;
  assign busy      = !reset && (r_state != ST_IDLE);
  assign done      = !reset && (r_state == ST_DONE);

endmodule : psum_drain

`default_nettype wire

// File: tb/tb_psum_drain.sv
//------------------------------------------------------------------------------
// Module   : tb_psum_drain
// Purpose  : Directed self-checking bench for psum_drain with behavioural
//            OFIFO and 1-cycle-latency SRAM models.
// Options  : PSUM_RELU_EN - selects the expected last-pass ReLU result.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_psum_drain;

  localparam int AW = 11;
  localparam int W  = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] len = '0;
  logic [AW-1:0] base_addr = '0;
  logic          first_pass = 1'b0;
  logic          last_pass = 1'b0;
  logic          ofifo_valid;
  logic [W-1:0]  ofifo_output;
  logic          ofifo_rd;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [W-1:0]  sram_din;
  logic [W-1:0]  sram_dout = '0;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  psum_drain #(.col(8), .psum_bw(16), .addr_bw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .base_addr(base_addr),
    .first_pass(first_pass), .last_pass(last_pass),
    .ofifo_valid(ofifo_valid), .ofifo_output(ofifo_output), .ofifo_rd(ofifo_rd),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout), .busy(busy), .done(done)
  );

  // SRAM model with a preload port for the bench
  logic [W-1:0]  mem [0:2047];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [W-1:0]  pl_data = '0;
  int            wr_cnt = 0;
  int            rd_cnt = 0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!sram_cen && !sram_wen) begin
      mem[sram_addr] <= sram_din;
      wr_cnt <= wr_cnt + 1;
    end
    if (!sram_cen && sram_wen) begin
      sram_dout <= mem[sram_addr];
      rd_cnt <= rd_cnt + 1;
    end
  end

  // OFIFO model
  logic [W-1:0] fifo [0:15];
  int           wp = 0;
  int           rp = 0;
  logic         en_valid = 1'b1;

  assign ofifo_valid  = en_valid && (wp != rp);
  assign ofifo_output = fifo[rp[3:0]];

  always @(posedge clk) if (ofifo_rd) rp <= rp + 1;

  int done_cnt = 0;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // lane 0 = l0, other even lanes = ev, odd lanes = od
  function automatic logic [W-1:0] mk(input int l0, input int ev, input int od);
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)          r[i*16 +: 16] = 16'(l0);
      else if (i % 2 == 0) r[i*16 +: 16] = 16'(ev);
      else                 r[i*16 +: 16] = 16'(od);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rep(input int v);
    return mk(v, v, v);
  endfunction

  task automatic push(input logic [W-1:0] row);
    fifo[wp[3:0]] = row;
    wp = wp + 1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Returns at the negedge of the first cycle after the start edge.
  task automatic run_start(input int l, input int b, input logic fp, input logic lp);
    @(negedge clk);
    start = 1'b1; len = AW'(l); base_addr = AW'(b); first_pass = fp; last_pass = lp;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) check("done_timeout", W'(0), W'(1));
  endtask

  int cyc, d0, w0, r0, stall_bad;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_cen",  W'(sram_cen), W'(1));
    check("rst_wen",  W'(sram_wen), W'(1));
    check("rst_addr", W'(sram_addr), W'(0));
    check("rst_din",  sram_din, W'(0));
    check("rst_rd",   W'(ofifo_rd), W'(0));
    reset = 1'b0;
    @(negedge clk);

    // First pass, len=2, base=5: timing of 3 cycles per vector + done
    push(rep(3)); push(rep(7));
    d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt;
    run_start(2, 5, 1'b1, 1'b0);
    check("a_busy", W'(busy), W'(1));
    wait_done(cyc);
    check("a_latency", W'(cyc), W'(7));
    @(negedge clk);
    check("a_done_drop", W'(done), W'(0));
    check("a_busy_idle", W'(busy), W'(0));
    check("a_mem5", mem[5], rep(3));
    check("a_mem6", mem[6], rep(7));
    check("a_done_cnt", W'(done_cnt - d0), W'(1));
    check("a_writes", W'(wr_cnt - w0), W'(2));
    check("a_reads", W'(rd_cnt - r0), W'(0));

    // Accumulate: 100 + -30 = 70
    preload(0, rep(100));
    push(rep(-30));
    r0 = rd_cnt;
    run_start(1, 0, 1'b0, 1'b0);
    wait_done(cyc);
    @(negedge clk);
    check("acc_mem0", mem[0], rep(70));
    check("acc_reads", W'(rd_cnt - r0), W'(1));

    // Saturation both directions, lane-interleaved
    preload(10, mk(32000, 32000, -32000));
    push(mk(1000, 1000, -1000));
    run_start(1, 10, 1'b0, 1'b0);
    wait_done(cyc);
    @(negedge clk);
    check("sat_mem10", mem[10], mk(32767, 32767, -32768));

    // Last pass: lane0 10+5=15, others -10+5=-5
    preload(20, mk(10, -10, -10));
    push(rep(5));
    run_start(1, 20, 1'b0, 1'b1);
    wait_done(cyc);
    @(negedge clk);
`ifdef PSUM_RELU_EN
    check("relu_mem20", mem[20], mk(15, 0, 0));
`else
    check("relu_mem20", mem[20], mk(15, -5, -5));
`endif

    // Stall: no valid row for 10 cycles in FETCH
    w0 = wr_cnt; stall_bad = 0;
    run_start(1, 30, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (ofifo_rd || !sram_cen || !sram_wen) stall_bad++;
      @(negedge clk);
    end
    check("stall_strobes", W'(stall_bad), W'(0));
    check("stall_busy", W'(busy), W'(1));
    push(rep(42));
    wait_done(cyc);
    @(negedge clk);
    check("stall_mem30", mem[30], rep(42));
    check("stall_writes", W'(wr_cnt - w0), W'(1));

    // Reset during ADD
    preload(40, rep(1));
    push(rep(9));
    d0 = done_cnt; w0 = wr_cnt;
    run_start(1, 40, 1'b1, 1'b0);   // cycle 1: FETCH
    @(negedge clk);                 // cycle 2: ADD
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rstadd_busy", W'(busy), W'(0));
    check("rstadd_mem40", mem[40], rep(1));
    check("rstadd_writes", W'(wr_cnt - w0), W'(0));
    check("rstadd_done", W'(done_cnt - d0), W'(0));

    // len = 0: done on the cycle after start, no SRAM access
    d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt;
    run_start(0, 60, 1'b0, 1'b0);
    check("len0_done", W'(done), W'(1));
    @(negedge clk);
    check("len0_drop", W'(done), W'(0));
    check("len0_busy", W'(busy), W'(0));
    check("len0_access", W'((wr_cnt - w0) + (rd_cnt - r0)), W'(0));

    // Start while busy is ignored
    d0 = done_cnt; w0 = wr_cnt;
    run_start(1, 50, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; len = AW'(0); base_addr = AW'(60);
    @(negedge clk);
    start = 1'b0;
    push(rep(4));
    wait_done(cyc);
    repeat (3) @(negedge clk);
    check("busy_mem50", mem[50], rep(4));
    check("busy_writes", W'(wr_cnt - w0), W'(1));
    check("busy_done_cnt", W'(done_cnt - d0), W'(1));

    // Address wrap at 2^addr_bw
    push(rep(11)); push(rep(12));
    run_start(2, 2047, 1'b1, 1'b0);
    wait_done(cyc);
    @(negedge clk);
    check("wrap_mem2047", mem[2047], rep(11));
    check("wrap_mem0", mem[0], rep(12));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_psum_drain

`default_nettype wire
